// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, WB control
// bit positions and default widths.
package mem_access_stage_pkg;

    localparam int REG_WIDTH     = 16;
    localparam int ADDR_BITS     = 3;
    localparam int CONTROL_BITS  = 2;
    localparam int CNT_WIDTH     = 8;   // wide enough for a 255-cycle timeout
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMTOREG = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_stage_timeout.sv
// Watchdog counter for an outstanding memory access; raises terminal on the
// last cycle the stage is allowed to wait for an acknowledge.
module mem_timeout_counter
    import mem_access_stage_pkg::*;
#(
    parameter int TimeoutCycles = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TimeoutCycles - 1);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: passes ALU results through and runs loads/stores against a
// req/ack data memory, stalling upstream and aborting on watchdog timeout.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int RegWidth      = REG_WIDTH,
    parameter int AddrBits      = ADDR_BITS,
    parameter int ControlBits   = CONTROL_BITS,
    parameter int TimeoutCycles = 15
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Valid_In,
    input  logic                   MemRead_In,
    input  logic                   MemWrite_In,
    input  logic [ControlBits-1:0] Control_In,
    input  logic [RegWidth-1:0]    ALUOut_In,
    input  logic [RegWidth-1:0]    StoreData_In,
    input  logic [AddrBits-1:0]    DestReg_In,
    output logic                   Stall_Out,
    output logic                   Valid_Out,
    output logic [ControlBits-1:0] Control_Out,
    output logic [RegWidth-1:0]    ALUOut_Out,
    output logic [RegWidth-1:0]    MemOut_Out,
    output logic [AddrBits-1:0]    DestReg_Out,
    output logic                   Fault_Out,
    output logic                   Mem_Req,
    output logic                   Mem_We,
    output logic [RegWidth-1:0]    Mem_Addr,
    output logic [RegWidth-1:0]    Mem_WData,
    input  logic [RegWidth-1:0]    Mem_RData,
    input  logic                   Mem_Ack,
    output state_t                 State_Dbg
);

    state_t                 state, state_next;
    logic                   memop;
    logic                   terminal;
    logic                   lat_we;
    logic [RegWidth-1:0]    lat_addr;
    logic [RegWidth-1:0]    lat_wdata;
    logic [ControlBits-1:0] lat_ctrl;
    logic [AddrBits-1:0]    lat_dest;

    assign memop     = Valid_In && (MemRead_In || MemWrite_In);
    assign State_Dbg = state;

    // Handshake: Mem_Req stays high with stable Mem_We/Mem_Addr/Mem_WData for
    // every WAIT cycle; the access completes in the first cycle Mem_Ack is seen.
    assign Mem_We    = lat_we;
    assign Mem_Addr  = lat_addr;
    assign Mem_WData = lat_wdata;

    mem_timeout_counter #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RST),
        .clear   (state_next != WAIT),
        .enable  (state == WAIT),
        .terminal(terminal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Stall_Out  = 1'b0;
        Mem_Req    = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    state_next = WAIT;
                    Stall_Out  = !RST;
                end
            end
            WAIT: begin
                Mem_Req   = !RST;
                Stall_Out = !RST && !Mem_Ack && !terminal;
                if (Mem_Ack || terminal) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Valid_Out   <= 1'b0;
            Control_Out <= '0;
            ALUOut_Out  <= '0;
            MemOut_Out  <= '0;
            DestReg_Out <= '0;
            Fault_Out   <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_ctrl    <= '0;
            lat_dest    <= '0;
        end else begin
            Fault_Out <= 1'b0;
            case (state)
                IDLE: begin
                    if (memop) begin
                        lat_we      <= MemWrite_In;
                        lat_addr    <= ALUOut_In;
                        lat_wdata   <= StoreData_In;
                        lat_ctrl    <= Control_In;
                        lat_dest    <= DestReg_In;
                        Valid_Out   <= 1'b0;
                        Control_Out <= '0;
                    end else if (Valid_In) begin
                        Valid_Out   <= 1'b1;
                        Control_Out <= Control_In;
                        ALUOut_Out  <= ALUOut_In;
                        MemOut_Out  <= '0;
                        DestReg_Out <= DestReg_In;
                    end else begin
                        Valid_Out   <= 1'b0;
                        Control_Out <= '0;
                    end
                end
                WAIT: begin
                    // An ack arriving on the terminal cycle still completes normally.
                    if (Mem_Ack) begin
                        Valid_Out   <= 1'b1;
                        Control_Out <= lat_ctrl;
                        ALUOut_Out  <= lat_addr;
                        MemOut_Out  <= lat_we ? '0 : Mem_RData;
                        DestReg_Out <= lat_dest;
                    end else if (terminal) begin
                        Valid_Out   <= 1'b1;
                        Control_Out <= '0;
                        ALUOut_Out  <= lat_addr;
                        MemOut_Out  <= '0;
                        DestReg_Out <= lat_dest;
                        Fault_Out   <= 1'b1;
                    end else begin
                        Valid_Out   <= 1'b0;
                        Control_Out <= '0;
                    end
                end
                default: begin
                    Valid_Out   <= 1'b0;
                    Control_Out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a driver issues instructions, a memory
// responder answers requests, and a monitor scores results against exp_q.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [2:0]  dest;
        logic        fault;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [7:0]  delay;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read_in, mem_write_in;
    logic [1:0]  control_in;
    logic [15:0] alu_in, store_in;
    logic [2:0]  dest_in;
    logic        stall_out, valid_out, fault_out;
    logic [1:0]  control_out;
    logic [15:0] alu_out, mem_out;
    logic [2:0]  dest_out;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    state_t      state_dbg;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [15:0] ref_mem[16];
    logic [15:0] resp_mem[16];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        resp_en = 1'b1;
    logic        force_ack = 1'b0;

    mem_access_stage #(
        .RegWidth(16), .AddrBits(3), .ControlBits(2), .TimeoutCycles(TO)
    ) dut (
        .CLK(clk), .RST(rst), .Valid_In(valid_in), .MemRead_In(mem_read_in),
        .MemWrite_In(mem_write_in), .Control_In(control_in), .ALUOut_In(alu_in),
        .StoreData_In(store_in), .DestReg_In(dest_in), .Stall_Out(stall_out),
        .Valid_Out(valid_out), .Control_Out(control_out), .ALUOut_Out(alu_out),
        .MemOut_Out(mem_out), .DestReg_Out(dest_out), .Fault_Out(fault_out),
        .Mem_Req(mem_req), .Mem_We(mem_we), .Mem_Addr(mem_addr),
        .Mem_WData(mem_wdata), .Mem_RData(mem_rdata), .Mem_Ack(mem_ack),
        .State_Dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Memory responder: answers each request after its planned delay.
    initial begin
        req_t cur;
        int   req_cycles;
        logic in_req;
        in_req = 1'b0;
        req_cycles = 0;
        cur = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_rdata = 16'($urandom);
            if (!resp_en) begin
                mem_ack = force_ack;
            end else if (mem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    req_cycles = 0;
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 32'(mem_req), 32'(0));
                    end else begin
                        cur = req_q.pop_front();
                    end
                end
                check("mem_we", 32'(mem_we), 32'(cur.we));
                check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                if (cur.we) check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
                if (req_cycles == int'(cur.delay)) begin
                    mem_ack = 1'b1;
                    if (cur.we) resp_mem[cur.addr[3:0]] = cur.wdata;
                    else mem_rdata = resp_mem[cur.addr[3:0]];
                end else begin
                    mem_ack = 1'b0;
                end
                req_cycles++;
            end else begin
                if (in_req) begin
                    check("req_length", 32'(req_cycles),
                          32'((int'(cur.delay) + 1 < TO) ? int'(cur.delay) + 1 : TO));
                end
                in_req = 1'b0;
                mem_ack = 1'($urandom_range(0, 1));  // stray acks must be ignored
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(valid_out), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("control_out", 32'(control_out), 32'(e.ctrl));
                    check("aluout_out", 32'(alu_out), 32'(e.alu));
                    check("memout_out", 32'(mem_out), 32'(e.mem));
                    check("fault_out", 32'(fault_out), 32'(e.fault));
                    if (!e.fault) check("destreg_out", 32'(dest_out), 32'(e.dest));
                end
            end else if (fault_out) begin
                check("fault_without_valid", 32'(fault_out), 32'(0));
            end
        end
    end

    // Driver: one instruction (or bubble) per call, held while stalled.
    task automatic do_op();
        int   kind;
        int   delay;
        int   stall_n;
        int   exp_stall;
        logic acked;
        logic [1:0] rw;
        exp_t e;
        req_t r;
        kind = $urandom_range(0, 9);
        @(negedge clk);
        control_in = 2'($urandom);
        alu_in = 16'($urandom);
        store_in = 16'($urandom);
        dest_in = 3'($urandom);
        if (kind < 2) begin
            valid_in = 1'b0;
            mem_read_in = 1'($urandom);
            mem_write_in = 1'($urandom);
            return;
        end
        valid_in = 1'b1;
        if (kind < 5) begin
            mem_read_in = 1'b0;
            mem_write_in = 1'b0;
            e = '{ctrl: control_in, alu: alu_in, mem: 16'h0, dest: dest_in, fault: 1'b0};
            exp_q.push_back(e);
            #2;
            check("stall_nonmem", 32'(stall_out), 32'(0));
            return;
        end
        rw = 2'($urandom_range(1, 3));
        mem_read_in = rw[0];
        mem_write_in = rw[1];
        delay = $urandom_range(0, 5);
        acked = (delay <= TO - 1);
        r = '{we: mem_write_in, addr: alu_in, wdata: store_in, delay: 8'(delay)};
        req_q.push_back(r);
        if (acked) begin
            e = '{ctrl: control_in, alu: alu_in,
                  mem: mem_write_in ? 16'h0 : ref_mem[alu_in[3:0]],
                  dest: dest_in, fault: 1'b0};
            if (mem_write_in) ref_mem[alu_in[3:0]] = store_in;
        end else begin
            e = '{ctrl: 2'b00, alu: alu_in, mem: 16'h0, dest: dest_in, fault: 1'b1};
        end
        exp_q.push_back(e);
        exp_stall = ((delay < TO - 1) ? delay : TO - 1) + 1;
        stall_n = 0;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (!stall_out) break;
            stall_n++;
            @(negedge clk);
        end
        check("stall_cycles", 32'(stall_n), 32'(exp_stall));
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
        check("drain_exp_q", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(valid_out), 32'(0));
        check({tag, "_control"}, 32'(control_out), 32'(0));
        check({tag, "_aluout"}, 32'(alu_out), 32'(0));
        check({tag, "_memout"}, 32'(mem_out), 32'(0));
        check({tag, "_destreg"}, 32'(dest_out), 32'(0));
        check({tag, "_fault"}, 32'(fault_out), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        mem_read_in = 1'b0;
        mem_write_in = 1'b0;
        control_in = '0;
        alu_in = '0;
        store_in = '0;
        dest_in = '0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'($urandom);
            resp_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        #2;
        check("reset_mem_req", 32'(mem_req), 32'(0));
        check("reset_stall", 32'(stall_out), 32'(0));
        check_outputs_zero("reset");
        rst = 1'b0;

        repeat (300) do_op();
        @(negedge clk);
        valid_in = 1'b0;
        drain();

        // Reset in the second WAIT cycle abandons the load.
        resp_en = 1'b0;
        force_ack = 1'b0;
        @(negedge clk);
        valid_in = 1'b1;
        mem_read_in = 1'b1;
        mem_write_in = 1'b0;
        control_in = 2'b11;
        alu_in = 16'h0040;
        dest_in = 3'd6;
        @(negedge clk);
        #2;
        check("rst_test_req_wait1", 32'(mem_req), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("rst_test_req_low", 32'(mem_req), 32'(0));
        check("rst_test_stall_low", 32'(stall_out), 32'(0));
        @(negedge clk);
        #2;
        check_outputs_zero("rst_test");
        rst = 1'b0;
        valid_in = 1'b0;
        mem_read_in = 1'b0;
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #2;
            check("late_ack_valid", 32'(valid_out), 32'(0));
            check("late_ack_fault", 32'(fault_out), 32'(0));
            check("late_ack_req", 32'(mem_req), 32'(0));
        end
        force_ack = 1'b0;
        resp_en = 1'b1;

        repeat (40) do_op();
        @(negedge clk);
        valid_in = 1'b0;
        drain();
        check("req_q_empty", 32'(req_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
